// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: START, DATA_W data bits LSB first, optional even
// parity, STOP. Every bit is held DIV clocks; sout_en strobes on the first clock of each bit.
module piso_serializer #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DIV       = 4,
   parameter int unsigned PARITY_EN = 1
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              sout,
   output logic              sout_en,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BIT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e              r_state, w_state_d;
   logic [CNT_W-1:0]    r_cnt, w_cnt_d;
   logic [BIT_W-1:0]    r_bit, w_bit_d;
   logic [DATA_W-1:0]   r_data, w_data_d;
   logic                r_sout, w_sout_d;
   logic                r_sout_en, w_sout_en_d;

   logic                w_bit_end;
   logic                w_accept;
   logic [BIT_W-1:0]    w_bit_inc;

   assign w_bit_end  = (r_cnt == CNT_LAST);
   assign w_bit_inc  = r_bit + 1'b1;
   assign din_ready  = (r_state == StIdle) && !Reset;
   assign w_accept   = din_valid && din_ready;

   assign sout       = r_sout;
   assign sout_en    = r_sout_en;
   assign busy       = (r_state != StIdle);
   assign frame_done = (r_state == StStop) && w_bit_end;

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_data    <= '0;
         r_sout    <= 1'b1;
         r_sout_en <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_cnt     <= w_cnt_d;
         r_bit     <= w_bit_d;
         r_data    <= w_data_d;
         r_sout    <= w_sout_d;
         r_sout_en <= w_sout_en_d;
      end
   end

   // sout is computed one clock ahead so it changes on the edge that enters each bit.
   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = w_bit_end ? '0 : r_cnt + 1'b1;
      w_bit_d     = r_bit;
      w_data_d    = r_data;
      w_sout_d    = r_sout;
      w_sout_en_d = 1'b0;

      case (r_state)
         StIdle: begin
            w_cnt_d  = '0;
            w_sout_d = 1'b1;
            if (w_accept) begin
               w_state_d   = StStart;
               w_data_d    = din;
               w_sout_d    = 1'b0;
               w_sout_en_d = 1'b1;
            end
         end
         StStart: begin
            if (w_bit_end) begin
               w_state_d   = StData;
               w_bit_d     = '0;
               w_sout_d    = r_data[0];
               w_sout_en_d = 1'b1;
            end
         end
         StData: begin
            if (w_bit_end) begin
               w_sout_en_d = 1'b1;
               if (r_bit == BIT_LAST) begin
                  w_bit_d = '0;
                  if (PARITY_EN != 0) begin
                     w_state_d = StParity;
                     w_sout_d  = ^r_data;
                  end else begin
                     w_state_d = StStop;
                     w_sout_d  = 1'b1;
                  end
               end else begin
                  w_bit_d  = w_bit_inc;
                  w_sout_d = r_data[w_bit_inc];
               end
            end
         end
         StParity: begin
            if (w_bit_end) begin
               w_state_d   = StStop;
               w_sout_d    = 1'b1;
               w_sout_en_d = 1'b1;
            end
         end
         StStop: begin
            if (w_bit_end) begin
               w_state_d = StIdle;
               w_sout_d  = 1'b1;
            end
         end
         default: begin
            w_state_d = StIdle;
            w_sout_d  = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Drives three serializer configurations from shared inputs and compares every cycle
// against a queue-of-expected-cycles model built from the frame format.
module tb_piso_serializer;

   logic       clk;
   logic       Reset;
   logic [7:0] din;
   logic       din_valid;

   logic [2:0] w_ready, w_sout, w_en, w_busy, w_fd;

   // Config 0: DIV=1 parity; config 1: DIV=4 parity; config 2: DIV=2 no parity.
   int divs[3] = '{1, 4, 2};
   int pars[3] = '{1, 1, 0};

   typedef struct packed {
      logic s;
      logic e;
      logic f;
   } exp_t;

   exp_t mq[3][$];

   int checks   = 0;
   int failures = 0;

   piso_serializer #(.DATA_W(8), .DIV(1), .PARITY_EN(1)) u_dut0 (
      .clk(clk), .Reset(Reset), .din(din), .din_valid(din_valid), .din_ready(w_ready[0]),
      .sout(w_sout[0]), .sout_en(w_en[0]), .busy(w_busy[0]), .frame_done(w_fd[0])
   );
   piso_serializer #(.DATA_W(8), .DIV(4), .PARITY_EN(1)) u_dut1 (
      .clk(clk), .Reset(Reset), .din(din), .din_valid(din_valid), .din_ready(w_ready[1]),
      .sout(w_sout[1]), .sout_en(w_en[1]), .busy(w_busy[1]), .frame_done(w_fd[1])
   );
   piso_serializer #(.DATA_W(8), .DIV(2), .PARITY_EN(0)) u_dut2 (
      .clk(clk), .Reset(Reset), .din(din), .din_valid(din_valid), .din_ready(w_ready[2]),
      .sout(w_sout[2]), .sout_en(w_en[2]), .busy(w_busy[2]), .frame_done(w_fd[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int d, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s dut%0d t=%0t observed=%b expected=%b", tag, d, $time, obs, exp);
      end
   endtask

   // One entry per clock of the frame: bit value, first-clock strobe, last-clock pulse.
   task automatic build(input int i, input logic [7:0] w);
      logic b[$];
      exp_t e;
      b.push_back(1'b0);
      for (int k = 0; k < 8; k++) b.push_back(w[k]);
      if (pars[i] != 0) b.push_back(^w);
      b.push_back(1'b1);
      for (int n = 0; n < b.size(); n++) begin
         for (int j = 0; j < divs[i]; j++) begin
            e.s = b[n];
            e.e = (j == 0);
            e.f = (n == b.size() - 1) && (j == divs[i] - 1);
            mq[i].push_back(e);
         end
      end
   endtask

   task automatic tick();
      exp_t e;
      logic busy_e;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (Reset) mq[i].delete();
         else if (mq[i].size() != 0) void'(mq[i].pop_front());
         else if (din_valid) build(i, din);
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         busy_e = (mq[i].size() != 0);
         if (busy_e) e = mq[i][0];
         else begin
            e.s = 1'b1;
            e.e = 1'b0;
            e.f = 1'b0;
         end
         chk("sout", i, w_sout[i], e.s);
         chk("sout_en", i, w_en[i], e.e);
         chk("frame_done", i, w_fd[i], e.f);
         chk("busy", i, w_busy[i], busy_e);
         chk("din_ready", i, w_ready[i], !busy_e && !Reset);
      end
   endtask

   task automatic send_one(input logic [7:0] w, input int idle_after);
      din       = w;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      din       = 8'($urandom);
      repeat (idle_after) tick();
   endtask

   initial begin
      // Reset with a valid word present: reset wins, nothing accepted.
      Reset     = 1'b1;
      din_valid = 1'b1;
      din       = 8'($urandom);
      repeat (3) tick();
      Reset     = 1'b0;
      din_valid = 1'b0;
      repeat (2) tick();

      send_one(8'hA5, 50);
      send_one(8'h01, 50);
      send_one(8'hFF, 50);

      // Valid held high with fresh data each cycle across many frames.
      din_valid = 1'b1;
      for (int c = 0; c < 200; c++) begin
         din = 8'($urandom);
         tick();
      end
      din_valid = 1'b0;
      repeat (50) tick();

      // Abort during data bit 3 of the DIV=4 configuration.
      send_one(8'($urandom), 17);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      repeat (50) tick();

      // Reset coinciding with a handshake from idle.
      Reset     = 1'b1;
      din_valid = 1'b1;
      din       = 8'h5A;
      tick();
      Reset     = 1'b0;
      din_valid = 1'b0;
      repeat (3) tick();

      for (int c = 0; c < 1500; c++) begin
         din       = 8'($urandom);
         din_valid = ($urandom_range(0, 3) == 0);
         Reset     = ($urandom_range(0, 99) == 0);
         tick();
      end
      Reset     = 1'b0;
      din_valid = 1'b0;
      repeat (50) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
